// File: rtl/cmul_arbiter.sv
// cmul_arbiter: two requesters share one complex multiplier through a
// two-stage pipeline (S1 = registered operands, S2 = registered result).
// Round-robin arbitration between requesters; a full-pipeline stall holds
// both stages whenever the result is valid but not accepted downstream.
// Optional feature macro: CMUL_ARB_SAT_EN -- saturate the final add/sub
// instead of wrapping modulo 2^WIDTH.
module cmul_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid_0,
  output logic                    req_ready_0,
  input  logic signed [WIDTH-1:0] req_a_re_0,
  input  logic signed [WIDTH-1:0] req_a_im_0,
  input  logic signed [WIDTH-1:0] req_b_re_0,
  input  logic signed [WIDTH-1:0] req_b_im_0,
  input  logic                    req_valid_1,
  output logic                    req_ready_1,
  input  logic signed [WIDTH-1:0] req_a_re_1,
  input  logic signed [WIDTH-1:0] req_a_im_1,
  input  logic signed [WIDTH-1:0] req_b_re_1,
  input  logic signed [WIDTH-1:0] req_b_im_1,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] res_re,
  output logic signed [WIDTH-1:0] res_im,
  output logic                    res_id,
  output logic                    busy
);

  // Scaled product: full 2*WIDTH-bit product, arithmetic shift by WIDTH-1,
  // then keep only the low WIDTH bits (truncation, never saturation).
  function automatic logic signed [WIDTH-1:0] sc(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y
  );
    logic signed [2*WIDTH-1:0] p;
    logic signed [2*WIDTH-1:0] s;
    p = $signed({{WIDTH{x[WIDTH-1]}}, x}) * $signed({{WIDTH{y[WIDTH-1]}}, y});
    s = p >>> (WIDTH - 1);
    return s[WIDTH-1:0];
  endfunction

  // Reduce a WIDTH+1-bit sum to WIDTH bits: clamp or wrap.
  function automatic logic signed [WIDTH-1:0] fin(
    input logic signed [WIDTH:0] s
  );
    logic signed [WIDTH-1:0] r;
`ifdef CMUL_ARB_SAT_EN
    if (s[WIDTH] != s[WIDTH-1]) begin
      r = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      r = s[WIDTH-1:0];
    end
`else
    r = s[WIDTH-1:0];
`endif
    return r;
  endfunction

  // Pipeline registers
  logic                    r_s1_valid;
  logic                    r_s1_id;
  logic signed [WIDTH-1:0] r_s1_a_re;
  logic signed [WIDTH-1:0] r_s1_a_im;
  logic signed [WIDTH-1:0] r_s1_b_re;
  logic signed [WIDTH-1:0] r_s1_b_im;
  logic                    r_s2_valid;
  logic                    r_s2_id;
  logic signed [WIDTH-1:0] r_s2_re;
  logic signed [WIDTH-1:0] r_s2_im;
  // Round-robin pointer: id of the requester accepted most recently
  logic                    r_last;

  logic                    w_adv;
  logic                    w_grant_0;
  logic                    w_grant_1;
  logic                    w_acc_0;
  logic                    w_acc_1;
  logic                    w_acc;
  logic signed [WIDTH-1:0] w_sel_a_re;
  logic signed [WIDTH-1:0] w_sel_a_im;
  logic signed [WIDTH-1:0] w_sel_b_re;
  logic signed [WIDTH-1:0] w_sel_b_im;
  logic signed [WIDTH-1:0] w_p_rr;
  logic signed [WIDTH-1:0] w_p_ii;
  logic signed [WIDTH-1:0] w_p_ri;
  logic signed [WIDTH-1:0] w_p_ir;
  logic signed [WIDTH:0]   w_sum_re;
  logic signed [WIDTH:0]   w_sum_im;
  logic signed [WIDTH-1:0] w_re;
  logic signed [WIDTH-1:0] w_im;

  // Whole pipeline moves unless a valid result is being refused downstream
  assign w_adv = !(r_s2_valid && !res_ready);

  // Grant depends only on the valids and the pointer, never on ready
  assign w_grant_0 = req_valid_0 && (!req_valid_1 || r_last);
  assign w_grant_1 = req_valid_1 && (!req_valid_0 || !r_last);

  assign req_ready_0 = w_adv && w_grant_0;
  assign req_ready_1 = w_adv && w_grant_1;

  assign w_acc_0 = req_valid_0 && req_ready_0;
  assign w_acc_1 = req_valid_1 && req_ready_1;
  assign w_acc   = w_acc_0 || w_acc_1;

  // Operand mux toward S1 follows the grant
  always_comb begin
    w_sel_a_re = req_a_re_0;
    w_sel_a_im = req_a_im_0;
    w_sel_b_re = req_b_re_0;
    w_sel_b_im = req_b_im_0;
    if (w_grant_1) begin
      w_sel_a_re = req_a_re_1;
      w_sel_a_im = req_a_im_1;
      w_sel_b_re = req_b_re_1;
      w_sel_b_im = req_b_im_1;
    end
  end

  // Complex multiply from the S1 operands into the S2 result
  always_comb begin
    w_p_rr   = sc(r_s1_a_re, r_s1_b_re);
    w_p_ii   = sc(r_s1_a_im, r_s1_b_im);
    w_p_ri   = sc(r_s1_a_re, r_s1_b_im);
    w_p_ir   = sc(r_s1_a_im, r_s1_b_re);
    w_sum_re = {w_p_rr[WIDTH-1], w_p_rr} - {w_p_ii[WIDTH-1], w_p_ii};
    w_sum_im = {w_p_ri[WIDTH-1], w_p_ri} + {w_p_ir[WIDTH-1], w_p_ir};
    w_re     = fin(w_sum_re);
    w_im     = fin(w_sum_im);
  end

  // Pointer moves only when a pair is actually accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (w_acc) begin
      r_last <= w_acc_1;
    end
  end

  // S1: capture the granted operands, or go empty on an advance without accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s1_a_re  <= '0;
      r_s1_a_im  <= '0;
      r_s1_b_re  <= '0;
      r_s1_b_im  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_id   <= w_acc_1;
        r_s1_a_re <= w_sel_a_re;
        r_s1_a_im <= w_sel_a_im;
        r_s1_b_re <= w_sel_b_re;
        r_s1_b_im <= w_sel_b_im;
      end
    end
  end

  // S2: register the product of S1; held stable during a stall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_id    <= 1'b0;
      r_s2_re    <= '0;
      r_s2_im    <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_id <= r_s1_id;
        r_s2_re <= w_re;
        r_s2_im <= w_im;
      end
    end
  end

  assign res_valid = r_s2_valid;
  assign res_re    = r_s2_re;
  assign res_im    = r_s2_im;
  assign res_id    = r_s2_id;
  assign busy      = r_s1_valid || r_s2_valid;

endmodule
